// File: rtl/capture_uart_dumper_if.sv
// RAM read port and UART transmit handshake between capture_uart_dumper (master)
// and the capture RAM / UART transmitter (slave).
interface capture_uart_dumper_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [7:0]            uart_txd;
  logic                  uart_txd_strobe;
  logic                  uart_txd_ready;

  modport master (
    output rd_addr,
    output uart_txd,
    output uart_txd_strobe,
    input  rd_data,
    input  uart_txd_ready
  );

  modport slave (
    input  rd_addr,
    input  uart_txd,
    input  uart_txd_strobe,
    output rd_data,
    output uart_txd_ready
  );
endinterface

// File: rtl/capture_uart_dumper.sv
// Drains the capture RAM word by word onto the UART, MSB byte first plus zero pad bytes.
// Optional DUMP_SYNC_HEADER_EN: prefix every pass with the sync bytes 0xA5 0x5A.
module capture_uart_dumper #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned PAD_BYTES  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  capture_uart_dumper_if.master bus,
  output logic                  rearm_toggle,
  output logic                  busy
);

  localparam int unsigned WORD_BYTES  = DATA_WIDTH / 8;
  localparam int unsigned TOTAL_BYTES = WORD_BYTES + PAD_BYTES;
  localparam int unsigned CNT_W       = (TOTAL_BYTES < 3) ? 2 : $clog2(TOTAL_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TOTAL_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef DUMP_SYNC_HEADER_EN
    ST_HDR,
`endif
    ST_FETCH,
    ST_LOAD,
    ST_SEND
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  strobe_q;
  logic                  rearm_q;

  logic                  strobe;
  logic [7:0]            txd;
  logic                  rearm_flip;
  logic                  addr_inc;
  logic                  hdr_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Strobe and byte are decoded combinationally so the first byte goes out in the
  // first SEND/HDR cycle; strobe_q enforces the one idle cycle between strobes.
  always_comb begin
    state_nxt  = state;
    strobe     = 1'b0;
    txd        = 8'h00;
    rearm_flip = 1'b0;
    addr_inc   = 1'b0;
    hdr_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_FETCH;
          if (rd_addr_q == '0) begin
            rearm_flip = 1'b1;
`ifdef DUMP_SYNC_HEADER_EN
            state_nxt  = ST_HDR;
            hdr_start  = 1'b1;
`endif
          end
        end
      end
`ifdef DUMP_SYNC_HEADER_EN
      ST_HDR: begin
        if (cnt_q == '0) begin
          state_nxt = ST_FETCH;
        end else if (bus.uart_txd_ready && !strobe_q) begin
          strobe = 1'b1;
          txd    = (cnt_q == CNT_W'(2)) ? 8'hA5 : 8'h5A;
        end
      end
`endif
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SEND;
      ST_SEND: begin
        if (cnt_q == '0) begin
          state_nxt = ST_IDLE;
          addr_inc  = 1'b1;
        end else if (bus.uart_txd_ready && !strobe_q) begin
          strobe = 1'b1;
          txd    = shift_q[DATA_WIDTH-1 -: 8];
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      rearm_q   <= 1'b0;
    end else begin
      strobe_q <= strobe;
      if (rearm_flip) rearm_q <= ~rearm_q;
      if (addr_inc) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
      if (hdr_start) begin
        cnt_q <= CNT_W'(2);
      end else if (state == ST_LOAD) begin
        shift_q <= bus.rd_data;
        cnt_q   <= CNT_LOAD;
      end else if (strobe) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (state == ST_SEND) shift_q <= shift_q << 8;
      end
    end
  end

  assign bus.rd_addr         = rd_addr_q;
  assign bus.uart_txd        = txd;
  assign bus.uart_txd_strobe = strobe;
  assign rearm_toggle        = rearm_q;
  assign busy                = (state != ST_IDLE);

endmodule

// File: tb/tb_capture_uart_dumper.sv
// Directed bench for capture_uart_dumper: PAD_BYTES=2 and PAD_BYTES=0 instances on a
// 4-word RAM model; byte streams compared against hand-built expected sequences.
module tb_capture_uart_dumper;

`ifdef DUMP_SYNC_HEADER_EN
  localparam int H = 2;
`else
  localparam int H = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic enable_np = 1'b0;
  logic rearm, busy, rearm_np, busy_np;

  logic [31:0] mem [4];

  always #5 clk = ~clk;

  capture_uart_dumper_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus ();
  capture_uart_dumper_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus_np ();

  capture_uart_dumper #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .PAD_BYTES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus),
    .rearm_toggle(rearm), .busy(busy)
  );

  capture_uart_dumper #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .PAD_BYTES(0)) dut_np (
    .clk(clk), .reset_n(reset_n), .enable(enable_np), .bus(bus_np),
    .rearm_toggle(rearm_np), .busy(busy_np)
  );

  always @(posedge clk) begin
    bus.rd_data    <= mem[bus.rd_addr];
    bus_np.rd_data <= mem[bus_np.rd_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: byte capture and protocol observations at the falling edge.
  logic [7:0] got_q[$];
  logic [7:0] got_np_q[$];
  logic [7:0] exp_q[$];
  int  cyc = 0;
  int  adj_cnt = 0, adj_np_cnt = 0, stall_viol = 0, rearm_flips = 0;
  int  busy_rise_cyc = 0, first_strobe_cyc = -1;
  logic prev_strobe = 1'b0, prev_strobe_np = 1'b0, prev_busy = 1'b0, prev_rearm = 1'b0;
  logic rearm_at_rise = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      busy_rise_cyc    = cyc;
      first_strobe_cyc = -1;
      rearm_at_rise    = rearm;
    end
    if (bus.uart_txd_strobe) begin
      got_q.push_back(bus.uart_txd);
      if (prev_strobe) adj_cnt++;
      if (!bus.uart_txd_ready) stall_viol++;
      if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
    end
    if (bus_np.uart_txd_strobe) begin
      got_np_q.push_back(bus_np.uart_txd);
      if (prev_strobe_np) adj_np_cnt++;
    end
    if (rearm != prev_rearm && reset_n) rearm_flips++;
    prev_strobe    = bus.uart_txd_strobe;
    prev_strobe_np = bus_np.uart_txd_strobe;
    prev_busy      = busy;
    prev_rearm     = rearm;
  end

  task automatic wait_bytes(input bit np, input int n, input int budget, input string tag);
    int k = 0;
    while ((np ? got_np_q.size() : got_q.size()) < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= budget) check({tag, "_timeout"}, np ? got_np_q.size() : got_q.size(), n);
  endtask

  task automatic exp_hdr();
`ifdef DUMP_SYNC_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
`endif
  endtask

  task automatic exp_word(input int w, input int pad);
    logic [31:0] wv;
    wv = mem[w];
    for (int b = 0; b < 4; b++) exp_q.push_back(wv[31-8*b -: 8]);
    for (int p = 0; p < pad; p++) exp_q.push_back(8'h00);
  endtask

  task automatic exp_pass(input int pad);
    exp_hdr();
    for (int w = 0; w < 4; w++) exp_word(w, pad);
  endtask

  task automatic check_bytes(input string tag, input bit np, input int base);
    logic [7:0] g;
    int sz;
    sz = np ? got_np_q.size() : got_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < sz) g = np ? got_np_q[base+i] : got_q[base+i];
      else g = 8'hxx;
      check($sformatf("%s_b%0d", tag, i), {24'h0, g}, {24'h0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sz;
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    mem[2] = 32'h99AABBCC;
    mem[3] = 32'hDDEEFF00;
    bus.uart_txd_ready    = 1'b1;
    bus_np.uart_txd_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr",   {30'h0, bus.rd_addr}, 32'h0);
    check("rst_txd",    {24'h0, bus.uart_txd}, 32'h0);
    check("rst_strobe", {31'h0, bus.uart_txd_strobe}, 32'h0);
    check("rst_rearm",  {31'h0, rearm}, 32'h0);
    check("rst_busy",   {31'h0, busy}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'h0);

    // Two full passes, ready always high
    @(posedge clk); #1 enable = 1'b1;
    wait_bytes(0, 1, 50, "first_byte");
    check("latency", first_strobe_cyc - busy_rise_cyc, (H == 0) ? 2 : 0);
    check("rearm_at_start", {31'h0, rearm_at_rise}, 32'h1);
    wait_bytes(0, 2 * (24 + H), 2000, "two_pass");
    enable = 1'b0;
    exp_pass(2);
    exp_pass(2);
    check_bytes("pass12", 0, 0);
    repeat (10) @(negedge clk);
    check("rearm_flips2", rearm_flips, 2);
    check("wrap_addr", {30'h0, bus.rd_addr}, 32'h0);
    check("wait_busy", {31'h0, busy}, 32'h0);

    // Pass 3: stall mid-word 0, then drop enable after byte 2 of word 1
    base = got_q.size();
    @(posedge clk); #1 enable = 1'b1;
    wait_bytes(0, base + H + 2, 200, "pre_stall");
    bus.uart_txd_ready = 1'b0;
    sz = got_q.size();
    repeat (50) @(negedge clk);
    #1 check("stall_quiet", got_q.size(), sz);
    bus.uart_txd_ready = 1'b1;
    wait_bytes(0, base + H + 8, 200, "pre_drop");
    enable = 1'b0;
    repeat (40) @(negedge clk);
    #1 check("drop_bytes", got_q.size(), base + H + 12);
    check("drop_busy", {31'h0, busy}, 32'h0);
    check("drop_addr", {30'h0, bus.rd_addr}, 32'h2);
    @(posedge clk); #1 enable = 1'b1;
    wait_bytes(0, base + H + 24, 500, "pass3");
    exp_pass(2);
    check_bytes("pass3", 0, base);

    // Pass 4: asynchronous reset mid-word 2
    base = got_q.size();
    wait_bytes(0, base + H + 14, 500, "pre_reset");
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("arst_addr",   {30'h0, bus.rd_addr}, 32'h0);
    check("arst_txd",    {24'h0, bus.uart_txd}, 32'h0);
    check("arst_strobe", {31'h0, bus.uart_txd_strobe}, 32'h0);
    check("arst_rearm",  {31'h0, rearm}, 32'h0);
    check("arst_busy",   {31'h0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    base = got_q.size();
    wait_bytes(0, base + H + 6, 200, "restart");
    check("restart_rearm", {31'h0, rearm}, 32'h1);
    enable = 1'b0;
    exp_hdr();
    exp_word(0, 2);
    check_bytes("restart", 0, base);

    // PAD_BYTES=0 instance: one pass plus the wrap back to word 0
    @(posedge clk); #1 enable_np = 1'b1;
    wait_bytes(1, 20 + 2 * H, 1000, "nopad");
    enable_np = 1'b0;
    exp_pass(0);
    exp_hdr();
    exp_word(0, 0);
    check_bytes("nopad", 1, 0);

    check("adjacent_strobes", adj_cnt, 0);
    check("adjacent_strobes_np", adj_np_cnt, 0);
    check("strobe_while_not_ready", stall_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
